// File: rtl/pc_source_ctrl.sv
// PC-source sequencer: resolves one instruction per request into a PC mux select and PC/EPC load strobes.
// Optional `PC_SOURCE_STATS_EN adds saturating taken-branch and exception counters.
module pc_source_ctrl #(
    parameter int MEM_LATENCY = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       gt,
    input  logic       overflow,
    input  logic       div_zero,
    output logic [2:0] pc_source,
    output logic       pc_write,
    output logic       epc_write,
    output logic [7:0] exc_addr,
`ifdef PC_SOURCE_STATS_EN
    output logic [15:0] taken_cnt,
    output logic [15:0] exc_cnt,
`endif
    output logic       done
);

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [2:0] {IDLE, RESOLVE, EXC_SAVE, EXC_WAIT, EXC_JUMP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [5:0]    op_q, fn_q;
    logic          zero_q, gt_q, ovf_q, dz_q;

    logic rtype, undef, ovf_exc, dz_exc, taken, is_j, is_jr, is_rte;

    always_comb begin
        rtype   = (op_q == 6'h00);
        undef   = !(op_q inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08,
                                 6'h0F, 6'h20, 6'h23, 6'h24, 6'h28, 6'h29, 6'h2B})
                  || (rtype && !(fn_q inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00,
                                              6'h02, 6'h03, 6'h04, 6'h07, 6'h08, 6'h13,
                                              6'h18, 6'h1A, 6'h10, 6'h12, 6'h05}));
        ovf_exc = ovf_q && ((rtype && (fn_q == 6'h20 || fn_q == 6'h22)) || op_q == 6'h08);
        dz_exc  = dz_q && rtype && (fn_q == 6'h1A);
        taken   = (op_q == 6'h04 && zero_q) || (op_q == 6'h05 && !zero_q) ||
                  (op_q == 6'h06 && (zero_q || !gt_q)) || (op_q == 6'h07 && gt_q);
        is_j    = (op_q == 6'h02) || (op_q == 6'h03);
        is_jr   = rtype && (fn_q == 6'h08);
        is_rte  = rtype && (fn_q == 6'h13);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            pc_source <= 3'b000;
            pc_write  <= 1'b0;
            epc_write <= 1'b0;
            exc_addr  <= 8'd0;
            done      <= 1'b0;
            cnt       <= '0;
            op_q      <= 6'd0;
            fn_q      <= 6'd0;
            zero_q    <= 1'b0;
            gt_q      <= 1'b0;
            ovf_q     <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            pc_write  <= 1'b0;
            epc_write <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: if (req_valid && req_ready) begin
                    op_q      <= opcode;
                    fn_q      <= funct;
                    zero_q    <= zero;
                    gt_q      <= gt;
                    ovf_q     <= overflow;
                    dz_q      <= div_zero;
                    req_ready <= 1'b0;
                    state     <= RESOLVE;
                end
                RESOLVE: begin
                    // exception priority: undefined opcode > overflow > divide-by-zero
                    if (undef || ovf_exc || dz_exc) begin
                        exc_addr  <= undef ? 8'd253 : (ovf_exc ? 8'd254 : 8'd255);
                        epc_write <= 1'b1;
                        state     <= EXC_SAVE;
                    end else begin
                        done      <= 1'b1;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                        if (taken) begin
                            pc_source <= 3'b001;
                            pc_write  <= 1'b1;
                        end else if (is_j) begin
                            pc_source <= 3'b010;
                            pc_write  <= 1'b1;
                        end else if (is_jr) begin
                            pc_source <= 3'b101;
                            pc_write  <= 1'b1;
                        end else if (is_rte) begin
                            pc_source <= 3'b011;
                            pc_write  <= 1'b1;
                        end
                    end
                end
                EXC_SAVE: begin
                    cnt   <= CW'(MEM_LATENCY - 1);
                    state <= EXC_WAIT;
                end
                EXC_WAIT: begin
                    if (cnt == '0) begin
                        pc_source <= 3'b100;
                        pc_write  <= 1'b1;
                        done      <= 1'b1;
                        state     <= EXC_JUMP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                EXC_JUMP: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef PC_SOURCE_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            taken_cnt <= 16'd0;
            exc_cnt   <= 16'd0;
        end else begin
            if (pc_write && pc_source == 3'b001 && taken_cnt != 16'hFFFF)
                taken_cnt <= taken_cnt + 16'd1;
            if (state == EXC_JUMP && exc_cnt != 16'hFFFF)
                exc_cnt <= exc_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_source_ctrl.sv
// Bench for pc_source_ctrl: directed vector table, multi-cycle corner sequences, random requests vs a rule model.
module tb_pc_source_ctrl;
    localparam int ML = 2;

    logic       clk = 1'b0, reset = 1'b1, req_valid = 1'b0;
    logic       req_ready, zero = 1'b0, gt = 1'b0, overflow = 1'b0, div_zero = 1'b0;
    logic [5:0] opcode = 6'd0, funct = 6'd0;
    logic [2:0] pc_source;
    logic       pc_write, epc_write, done;
    logic [7:0] exc_addr;
`ifdef PC_SOURCE_STATS_EN
    logic [15:0] taken_cnt, exc_cnt;
`endif

    always #5 clk = ~clk;

    pc_source_ctrl #(.MEM_LATENCY(ML)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .opcode(opcode), .funct(funct), .zero(zero), .gt(gt), .overflow(overflow),
        .div_zero(div_zero), .pc_source(pc_source), .pc_write(pc_write),
        .epc_write(epc_write), .exc_addr(exc_addr),
`ifdef PC_SOURCE_STATS_EN
        .taken_cnt(taken_cnt), .exc_cnt(exc_cnt),
`endif
        .done(done)
    );

    typedef struct {logic [5:0] op, fn; bit z, g, o, d;} req_t;
    typedef struct {bit exc; logic [7:0] addr; bit wr; logic [2:0] src;} exp_t;
    typedef struct {req_t r; exp_t e;} vec_t;

    int         n_cmp = 0, n_fail = 0;
    logic [2:0] cur_src = 3'b000;
    int         m_taken = 0, m_exc = 0;
    vec_t       tbl[$];
    logic [5:0] ops [15] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08,
                             6'h0F, 6'h20, 6'h23, 6'h24, 6'h28, 6'h29, 6'h2B};
    logic [5:0] fns [17] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h03, 6'h04,
                             6'h07, 6'h08, 6'h13, 6'h18, 6'h1A, 6'h10, 6'h12, 6'h05};

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [5:0] op, fn, bit z, g, o, d,
                                bit ex, logic [7:0] a, bit wr, logic [2:0] s);
        vec_t v;
        v.r = '{op: op, fn: fn, z: z, g: g, o: o, d: d};
        v.e = '{exc: ex, addr: a, wr: wr, src: s};
        return v;
    endfunction

    // Rule model: what the instruction should do, straight from the decode rules.
    function automatic exp_t model(req_t r);
        exp_t e = '{exc: 0, addr: 8'd0, wr: 0, src: 3'b000};
        bit rt = (r.op == 6'h00);
        bit op_ok = 0, fn_ok = 0;
        foreach (ops[i]) if (ops[i] == r.op) op_ok = 1;
        foreach (fns[i]) if (fns[i] == r.fn) fn_ok = 1;
        if (!op_ok || (rt && !fn_ok))                                       begin e.exc = 1; e.addr = 8'd253; end
        else if (r.o && ((rt && (r.fn == 6'h20 || r.fn == 6'h22)) || r.op == 6'h08)) begin e.exc = 1; e.addr = 8'd254; end
        else if (r.d && rt && r.fn == 6'h1A)                                 begin e.exc = 1; e.addr = 8'd255; end
        else begin
            case (r.op)
                6'h04: e.wr = r.z;
                6'h05: e.wr = !r.z;
                6'h06: e.wr = r.z || !r.g;
                6'h07: e.wr = r.g;
                default: e.wr = 0;
            endcase
            if (e.wr) e.src = 3'b001;
            else if (r.op == 6'h02 || r.op == 6'h03) begin e.wr = 1; e.src = 3'b010; end
            else if (rt && r.fn == 6'h08) begin e.wr = 1; e.src = 3'b101; end
            else if (rt && r.fn == 6'h13) begin e.wr = 1; e.src = 3'b011; end
        end
        return e;
    endfunction

    task automatic run_req(input req_t r, input exp_t e, input string tag);
        @(negedge clk);
        opcode = r.op; funct = r.fn; zero = r.z; gt = r.g; overflow = r.o; div_zero = r.d;
        req_valid = 1'b1;
        chk({tag, "/ready0"}, 16'(req_ready), 16'(1));
        @(negedge clk);
        // scramble inputs after transfer: the DUT must use the captured copy
        req_valid = 1'b0;
        opcode = 6'($urandom); funct = 6'($urandom); zero = 1'($urandom); gt = 1'($urandom);
        overflow = 1'($urandom); div_zero = 1'($urandom);
        chk({tag, "/c1_wr"}, 16'(pc_write), 16'(0));
        chk({tag, "/c1_ready"}, 16'(req_ready), 16'(0));
        @(negedge clk);
        if (!e.exc) begin
            if (e.wr) cur_src = e.src;
            if (e.wr && e.src == 3'b001) m_taken++;
            chk({tag, "/wr"}, 16'(pc_write), 16'(e.wr));
            chk({tag, "/src"}, 16'(pc_source), 16'(cur_src));
            chk({tag, "/done"}, 16'(done), 16'(1));
            chk({tag, "/epc"}, 16'(epc_write), 16'(0));
            @(negedge clk);
            chk({tag, "/done_clr"}, 16'(done), 16'(0));
            chk({tag, "/ready_back"}, 16'(req_ready), 16'(1));
        end else begin
            chk({tag, "/epc"}, 16'(epc_write), 16'(1));
            chk({tag, "/c2_wr"}, 16'(pc_write), 16'(0));
            chk({tag, "/addr"}, 16'(exc_addr), 16'(e.addr));
            for (int k = 3; k <= ML + 2; k++) begin
                @(negedge clk);
                chk({tag, "/wait_strobes"}, 16'({epc_write, pc_write, done}), 16'(0));
                chk({tag, "/wait_addr"}, 16'(exc_addr), 16'(e.addr));
            end
            @(negedge clk);
            cur_src = 3'b100;
            m_exc++;
            chk({tag, "/jmp_wr"}, 16'(pc_write), 16'(1));
            chk({tag, "/jmp_src"}, 16'(pc_source), 16'(4));
            chk({tag, "/jmp_done"}, 16'(done), 16'(1));
            chk({tag, "/jmp_epc"}, 16'(epc_write), 16'(0));
            @(negedge clk);
            chk({tag, "/ready_back"}, 16'(req_ready), 16'(1));
            chk({tag, "/wr_clr"}, 16'(pc_write), 16'(0));
        end
    endtask

    initial begin
        req_t r;
        tbl.push_back(mk(6'h04, 6'h00, 1, 0, 0, 0, 0, 8'd0,   1, 3'b001)); // beq taken
        tbl.push_back(mk(6'h05, 6'h00, 1, 0, 0, 0, 0, 8'd0,   0, 3'b000)); // bne not taken
        tbl.push_back(mk(6'h07, 6'h00, 0, 1, 0, 0, 0, 8'd0,   1, 3'b001)); // bgt taken
        tbl.push_back(mk(6'h00, 6'h20, 0, 0, 1, 0, 1, 8'd254, 0, 3'b000)); // add overflow
        tbl.push_back(mk(6'h3F, 6'h00, 0, 0, 1, 1, 1, 8'd253, 0, 3'b000)); // undef wins
        tbl.push_back(mk(6'h00, 6'h08, 0, 0, 0, 0, 0, 8'd0,   1, 3'b101)); // jr
        tbl.push_back(mk(6'h00, 6'h13, 0, 0, 0, 0, 0, 8'd0,   1, 3'b011)); // rte
        tbl.push_back(mk(6'h02, 6'h00, 0, 0, 0, 0, 0, 8'd0,   1, 3'b010)); // j
        tbl.push_back(mk(6'h03, 6'h00, 0, 0, 0, 0, 0, 8'd0,   1, 3'b010)); // jal
        tbl.push_back(mk(6'h06, 6'h00, 0, 1, 0, 0, 0, 8'd0,   0, 3'b000)); // ble not taken
        tbl.push_back(mk(6'h06, 6'h00, 0, 0, 0, 0, 0, 8'd0,   1, 3'b001)); // ble taken
        tbl.push_back(mk(6'h00, 6'h1A, 0, 0, 0, 1, 1, 8'd255, 0, 3'b000)); // div by zero
        tbl.push_back(mk(6'h08, 6'h00, 0, 0, 1, 0, 1, 8'd254, 0, 3'b000)); // addi overflow
        tbl.push_back(mk(6'h00, 6'h3F, 0, 0, 0, 0, 1, 8'd253, 0, 3'b000)); // bad funct
        tbl.push_back(mk(6'h23, 6'h00, 0, 0, 1, 1, 0, 8'd0,   0, 3'b000)); // lw, flags ignored
        tbl.push_back(mk(6'h00, 6'h1A, 0, 0, 1, 0, 0, 8'd0,   0, 3'b000)); // div ok
        tbl.push_back(mk(6'h04, 6'h00, 0, 0, 0, 0, 0, 8'd0,   0, 3'b000)); // beq not taken
        tbl.push_back(mk(6'h00, 6'h22, 0, 0, 1, 1, 1, 8'd254, 0, 3'b000)); // sub overflow

        // reset state
        repeat (2) @(negedge clk);
        chk("rst/outs", 16'({pc_source, pc_write, epc_write, done}), 16'(0));
        chk("rst/addr", 16'(exc_addr), 16'(0));
        reset = 1'b0;
        @(negedge clk);
        chk("rst/ready", 16'(req_ready), 16'(1));

        foreach (tbl[i]) run_req(tbl[i].r, tbl[i].e, $sformatf("vec%0d", i));

        // req_valid held through RESOLVE: second request only accepted back in IDLE
        @(negedge clk);
        opcode = 6'h04; funct = 6'h00; zero = 1'b1; gt = 1'b0; overflow = 1'b0; div_zero = 1'b0;
        req_valid = 1'b1;
        @(negedge clk);
        opcode = 6'h00; funct = 6'h08;
        chk("hold/c1_ready", 16'(req_ready), 16'(0));
        @(negedge clk);
        chk("hold/beq_src", 16'(pc_source), 16'(1));
        chk("hold/beq_wr", 16'(pc_write), 16'(1));
        m_taken++;
        @(negedge clk);
        req_valid = 1'b0;
        chk("hold/c3_wr", 16'(pc_write), 16'(0));
        @(negedge clk);
        chk("hold/jr_src", 16'(pc_source), 16'(5));
        chk("hold/jr_wr", 16'(pc_write), 16'(1));
        cur_src = 3'b101;

        // asynchronous reset in the middle of EXC_WAIT
        @(negedge clk);
        opcode = 6'h00; funct = 6'h22; overflow = 1'b1; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("arst/outs", 16'({pc_source, pc_write, epc_write, done}), 16'(0));
        chk("arst/addr", 16'(exc_addr), 16'(0));
        @(negedge clk);
        reset = 1'b0;
        cur_src = 3'b000;
        m_taken = 0;
        m_exc = 0;
        for (int k = 0; k < ML + 4; k++) begin
            @(negedge clk);
            chk("arst/no_wr", 16'({pc_write, epc_write}), 16'(0));
        end
        chk("arst/ready", 16'(req_ready), 16'(1));

        // random requests against the rule model
        for (int n = 0; n < 150; n++) begin
            r.op = ($urandom_range(3) != 0) ? ops[$urandom_range(14)] : 6'($urandom);
            r.fn = ($urandom_range(3) != 0) ? fns[$urandom_range(16)] : 6'($urandom);
            r.z = 1'($urandom); r.g = 1'($urandom);
            r.o = ($urandom_range(3) == 0); r.d = ($urandom_range(3) == 0);
            run_req(r, model(r), $sformatf("rnd%0d_op%0h_fn%0h", n, r.op, r.fn));
        end

`ifdef PC_SOURCE_STATS_EN
        @(negedge clk);
        chk("stats/taken", taken_cnt, 16'(m_taken));
        chk("stats/exc", exc_cnt, 16'(m_exc));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
